// File: rtl/prio_req_ctrl.sv
// prio_req_ctrl: event capture, masking and non-preemptive service handshake
// around an 8-line one-hot priority encoder (i out; h/idle back in).
//
// Ports:
//   clk, rst_n     clock; async active-low reset
//   ev[7:0]        event pulses, one per line
//   mask[7:0]      1 = line enabled for service
//   i[7:0]         request vector to the encoder (pend & mask)
//   h[7:0], idle   one-hot grant and "no request" flag from the encoder
//   req, id[2:0]   service request and index of the line in service
//   ack            handler done (sampled while req = 1)
//   busy           high while serving
//   ovf[7:0]       sticky: event hit an already-pending line
//   ovf_clr        clears ovf
//   err            sticky: grant protocol violation
module prio_req_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ev,
  input  logic [7:0] mask,
  output logic [7:0] i,
  input  logic [7:0] h,
  input  logic       idle,
  output logic       req,
  output logic [2:0] id,
  input  logic       ack,
  output logic       busy,
  output logic [7:0] ovf,
  input  logic       ovf_clr,
  output logic       err
);

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] pend;
  logic [7:0] cur;
  logic [7:0] clr;
  logic [7:0] ovf_set;
  logic       onehot;
  logic       go;
  logic       viol;
  logic [2:0] hidx;

  assign i = pend & mask;

  always_comb begin
    onehot = (h != 8'h00) && ((h & (h - 8'd1)) == 8'h00);
  end

  always_comb begin
    hidx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (h[k]) hidx = 3'(k);
    end
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    viol    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!idle && onehot) begin
          go      = 1'b1;
          state_n = SERVE;
        end else if (!idle || (h != 8'h00)) begin
          viol = 1'b1;
        end
      end
      SERVE: begin
        if (ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A new event on the line being acked re-arms it without counting
  // as an overflow.
  always_comb begin
    clr     = (state == SERVE && ack) ? cur : 8'h00;
    ovf_set = ev & pend & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= 8'h00;
      cur   <= 8'h00;
      id    <= 3'd0;
      ovf   <= 8'h00;
      req   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= ev | (pend & ~clr);
      ovf   <= ovf_set | (ovf_clr ? 8'h00 : ovf);
      req   <= (state_n == SERVE);
      busy  <= (state_n == SERVE);
      err   <= err | viol;
      if (go) begin
        cur <= h;
        id  <= hidx;
      end
    end
  end

endmodule

// File: tb/tb_prio_req_ctrl.sv
// tb_prio_req_ctrl: directed plus random check of prio_req_ctrl against
// a line-level reference model; the bench also plays the encoder.
module tb_prio_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ev;
  logic [7:0] mask;
  logic [7:0] i;
  logic [7:0] h;
  logic       idle;
  logic       req;
  logic [2:0] id;
  logic       ack;
  logic       busy;
  logic [7:0] ovf;
  logic       ovf_clr;
  logic       err;

  prio_req_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ev      (ev),
    .mask    (mask),
    .i       (i),
    .h       (h),
    .idle    (idle),
    .req     (req),
    .id      (id),
    .ack     (ack),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .err     (err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mpend;
  logic [7:0] movf;
  bit         mserv;
  int         mcur;
  bit         merr;

  bit         force_bad;
  logic [7:0] bad_h;
  logic       bad_idle;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpend = 8'h00;
    movf  = 8'h00;
    mserv = 1'b0;
    mcur  = 0;
    merr  = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] e, input logic a,
                            input logic oc, input logic [7:0] hh,
                            input logic il);
    int         cl;
    logic [7:0] np;
    logic [7:0] no;
    cl = (mserv && a) ? mcur : -1;
    np = mpend;
    no = oc ? 8'h00 : movf;
    for (int n = 0; n < 8; n++) begin
      if (e[n]) begin
        if (mpend[n] && n != cl) no[n] = 1'b1;
        np[n] = 1'b1;
      end else if (n == cl) begin
        np[n] = 1'b0;
      end
    end
    if (mserv) begin
      if (a) mserv = 1'b0;
    end else if (!il && $countones(hh) == 1) begin
      mserv = 1'b1;
      for (int n = 0; n < 8; n++) if (hh[n]) mcur = n;
    end else begin
      if (!il) merr = 1'b1;
      if (il && hh != 8'h00) merr = 1'b1;
    end
    mpend = np;
    movf  = no;
  endtask

  task automatic compare_all();
    chk("i", i, mpend & mask);
    chk("req", req, mserv);
    chk("busy", busy, mserv);
    chk("id", id, mcur);
    chk("ovf", ovf, movf);
    chk("err", err, merr);
  endtask

  task automatic step();
    logic [7:0] mi;
    logic [7:0] hh;
    logic [7:0] one;
    logic       il;
    one = 8'h01;
    mi  = mpend & mask;
    hh  = 8'h00;
    for (int n = 0; n < 8; n++) if (mi[n]) hh = one << n;
    il = (mi == 8'h00);
    if (force_bad) begin
      hh = bad_h;
      il = bad_idle;
    end
    h    = hh;
    idle = il;
    @(posedge clk);
    model_edge(ev, ack, ovf_clr, hh, il);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i", i, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_id", id, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input logic [7:0] e, input logic a);
    ev  = e;
    ack = a;
    step();
    ev  = 8'h00;
    ack = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    ev        = 8'h00;
    mask      = 8'hFF;
    h         = 8'h00;
    idle      = 1'b1;
    ack       = 1'b0;
    ovf_clr   = 1'b0;
    force_bad = 1'b0;
    bad_h     = 8'h00;
    bad_idle  = 1'b0;
    model_reset();
    #2;
    do_reset();

    // single event
    cyc(8'h08, 1'b0);
    chk("single_i", i, 8'h08);
    cyc(8'h00, 1'b0);
    chk("single_req", req, 1);
    chk("single_id", id, 3);
    cyc(8'h00, 1'b1);
    chk("single_done", {req, i, ovf, err}, 0);

    // priority order with one-cycle gap
    cyc(8'h81, 1'b0);
    chk("prio_i0", i, 8'h81);
    cyc(8'h00, 1'b0);
    chk("prio_id7", id, 7);
    cyc(8'h00, 1'b1);
    chk("prio_i1", i, 8'h01);
    chk("prio_gap", req, 0);
    cyc(8'h00, 1'b0);
    chk("prio_id0", {req, id}, {1'b1, 3'd0});
    cyc(8'h00, 1'b1);
    chk("prio_i2", i, 8'h00);

    // non-preemption
    cyc(8'h04, 1'b0);
    cyc(8'h00, 1'b0);
    cyc(8'h40, 1'b0);
    chk("np_hold", id, 2);
    cyc(8'h00, 1'b0);
    chk("np_hold2", id, 2);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);
    chk("np_next", {req, id}, {1'b1, 3'd6});
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    // collision: event on the acked line
    cyc(8'h04, 1'b0);
    cyc(8'h00, 1'b0);
    cyc(8'h04, 1'b1);
    chk("col_pend", i, 8'h04);
    chk("col_ovf", ovf, 8'h00);
    cyc(8'h00, 1'b0);
    chk("col_reserve", {req, id}, {1'b1, 3'd2});
    cyc(8'h04, 1'b0);
    chk("col_ovf2", ovf, 8'h04);
    ovf_clr = 1'b1;
    cyc(8'h00, 1'b0);
    ovf_clr = 1'b0;
    chk("col_ovfclr", ovf, 8'h00);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    // masking
    mask = 8'hEF;
    cyc(8'h10, 1'b0);
    cyc(8'h00, 1'b0);
    chk("mask_i", i, 8'h00);
    chk("mask_req", req, 0);
    mask = 8'hFF;
    cyc(8'h00, 1'b0);
    chk("mask_go", {req, id}, {1'b1, 3'd4});
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);

    // grant protocol error
    force_bad = 1'b1;
    bad_h     = 8'h18;
    bad_idle  = 1'b0;
    cyc(8'h00, 1'b0);
    force_bad = 1'b0;
    chk("err_set", err, 1);
    chk("err_noreq", req, 0);

    // reset mid-service
    cyc(8'h01, 1'b0);
    cyc(8'h20, 1'b0);
    chk("mid_req", req, 1);
    do_reset();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      if (t % 250 == 249) do_reset();
      ev      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack     = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) mask = 8'hFF;
      force_bad = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 2))
        0: begin bad_h = 8'h00; bad_idle = 1'b0; end
        1: begin bad_h = 8'h81; bad_idle = 1'b0; end
        default: begin bad_h = 8'h02; bad_idle = 1'b1; end
      endcase
      step();
    end
    force_bad = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
